// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter between the CPU ibus/dbus ports and sram_controller.
package sram_arbiter_pkg;

  typedef logic [19:0] Ram_addr_t;
  typedef logic [31:0] Word_t;
  typedef logic        Bit_t;
  typedef logic [3:0]  Byte_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } Sram_arb_state_t;

  typedef enum logic {
    OWNER_IBUS,
    OWNER_DBUS
  } Sram_owner_t;

  localparam Byte_mask_t FULL_MASK = 4'b1111;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant picker for the SRAM arbiter.
// SRAM_ARBITER_ROUND_ROBIN_EN selects round-robin on contention; otherwise dbus has fixed priority.
module sram_arb_grant
  import sram_arbiter_pkg::*;
(
  input  logic        ibus_req_i,
  input  logic        dbus_req_i,
  input  Sram_owner_t last_grant_i,
  output Sram_owner_t owner_o,
  output logic        grant_valid_o
);

  assign grant_valid_o = ibus_req_i | dbus_req_i;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    owner_o = OWNER_IBUS;
    if (ibus_req_i && dbus_req_i) begin
      owner_o = (last_grant_i == OWNER_DBUS) ? OWNER_IBUS : OWNER_DBUS;
    end else if (dbus_req_i) begin
      owner_o = OWNER_DBUS;
    end
  end
`else
  // Fixed priority ignores history; ibus can starve under continuous dbus traffic.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign owner_o = dbus_req_i ? OWNER_DBUS : OWNER_IBUS;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_controller between ibus (fetch) and dbus (load/store): latch, hold for
// ACCESS_CYCLES, then pulse ready for one cycle. Contention policy set by SRAM_ARBITER_ROUND_ROBIN_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  Ram_addr_t  ibus_addr,
  input  logic       ibus_read,
  output Word_t      ibus_data_read,
  output logic       ibus_ready,
  input  Ram_addr_t  dbus_addr,
  input  logic       dbus_read,
  input  logic       dbus_write,
  input  Word_t      dbus_data_write,
  input  Byte_mask_t dbus_byte_mask,
  output Word_t      dbus_data_read,
  output logic       dbus_ready,
  output Ram_addr_t  ctrl_addr,
  output logic       ctrl_read_op,
  output logic       ctrl_write_op,
  output Word_t      ctrl_data_write,
  output Byte_mask_t ctrl_byte_mask,
  input  Word_t      ctrl_data_read
);

  Sram_arb_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  Sram_owner_t      owner_q;
  Sram_owner_t      last_grant_q;
  Ram_addr_t        ctrl_addr_q;
  logic             ctrl_read_op_q;
  logic             ctrl_write_op_q;
  Word_t            ctrl_data_write_q;
  Byte_mask_t       ctrl_byte_mask_q;
  Word_t            ibus_data_read_q;
  Word_t            dbus_data_read_q;
  logic             ibus_ready_q;
  logic             dbus_ready_q;

  Sram_owner_t      grant_owner;
  logic             grant_valid;

  sram_arb_grant u_grant (
    .ibus_req_i    (ibus_read),
    .dbus_req_i    (dbus_read | dbus_write),
    .last_grant_i  (last_grant_q),
    .owner_o       (grant_owner),
    .grant_valid_o (grant_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      owner_q           <= OWNER_IBUS;
      last_grant_q      <= OWNER_IBUS;
      ctrl_addr_q       <= '0;
      ctrl_read_op_q    <= 1'b0;
      ctrl_write_op_q   <= 1'b0;
      ctrl_data_write_q <= '0;
      ctrl_byte_mask_q  <= '0;
      ibus_data_read_q  <= '0;
      dbus_data_read_q  <= '0;
      ibus_ready_q      <= 1'b0;
      dbus_ready_q      <= 1'b0;
    end else begin
      ibus_ready_q <= 1'b0;
      dbus_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            cnt_q        <= CNT_W'(ACCESS_CYCLES - 1);
            state_q      <= ACCESS;
            if (grant_owner == OWNER_DBUS) begin
              // A simultaneous read+write request is served as a write only.
              ctrl_addr_q       <= dbus_addr;
              ctrl_write_op_q   <= dbus_write;
              ctrl_read_op_q    <= ~dbus_write;
              ctrl_data_write_q <= dbus_write ? dbus_data_write : '0;
              ctrl_byte_mask_q  <= dbus_write ? dbus_byte_mask : FULL_MASK;
            end else begin
              ctrl_addr_q       <= ibus_addr;
              ctrl_write_op_q   <= 1'b0;
              ctrl_read_op_q    <= 1'b1;
              ctrl_data_write_q <= '0;
              ctrl_byte_mask_q  <= FULL_MASK;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (ctrl_read_op_q) begin
              if (owner_q == OWNER_DBUS) dbus_data_read_q <= ctrl_data_read;
              else                       ibus_data_read_q <= ctrl_data_read;
            end
            ctrl_read_op_q  <= 1'b0;
            ctrl_write_op_q <= 1'b0;
            dbus_ready_q    <= (owner_q == OWNER_DBUS);
            ibus_ready_q    <= (owner_q == OWNER_IBUS);
            state_q         <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_addr       = ctrl_addr_q;
  assign ctrl_read_op    = ctrl_read_op_q;
  assign ctrl_write_op   = ctrl_write_op_q;
  assign ctrl_data_write = ctrl_data_write_q;
  assign ctrl_byte_mask  = ctrl_byte_mask_q;
  assign ibus_data_read  = ibus_data_read_q;
  assign dbus_data_read  = dbus_data_read_q;
  assign ibus_ready      = ibus_ready_q;
  assign dbus_ready      = dbus_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural byte-masked SRAM on the ctrl side.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AC = 2;

  logic       clk = 1'b0;
  logic       rst;
  Ram_addr_t  ibus_addr;
  logic       ibus_read;
  Word_t      ibus_data_read;
  logic       ibus_ready;
  Ram_addr_t  dbus_addr;
  logic       dbus_read;
  logic       dbus_write;
  Word_t      dbus_data_write;
  Byte_mask_t dbus_byte_mask;
  Word_t      dbus_data_read;
  logic       dbus_ready;
  Ram_addr_t  ctrl_addr;
  logic       ctrl_read_op;
  logic       ctrl_write_op;
  Word_t      ctrl_data_write;
  Byte_mask_t ctrl_byte_mask;
  Word_t      ctrl_data_read;

  sram_arbiter #(.ACCESS_CYCLES(AC), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .ibus_addr       (ibus_addr),
    .ibus_read       (ibus_read),
    .ibus_data_read  (ibus_data_read),
    .ibus_ready      (ibus_ready),
    .dbus_addr       (dbus_addr),
    .dbus_read       (dbus_read),
    .dbus_write      (dbus_write),
    .dbus_data_write (dbus_data_write),
    .dbus_byte_mask  (dbus_byte_mask),
    .dbus_data_read  (dbus_data_read),
    .dbus_ready      (dbus_ready),
    .ctrl_addr       (ctrl_addr),
    .ctrl_read_op    (ctrl_read_op),
    .ctrl_write_op   (ctrl_write_op),
    .ctrl_data_write (ctrl_data_write),
    .ctrl_byte_mask  (ctrl_byte_mask),
    .ctrl_data_read  (ctrl_data_read)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM seen through the controller: combinational read, byte-masked write.
  Word_t mem [0:255];
  assign ctrl_data_read = mem[ctrl_addr[7:0]];
  always @(posedge clk) begin
    if (ctrl_write_op) begin
      for (int b = 0; b < 4; b++) begin
        if (ctrl_byte_mask[b]) mem[ctrl_addr[7:0]][8*b +: 8] <= ctrl_data_write[8*b +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    bit        is_dbus;
    Ram_addr_t addr;
    Word_t     data;
    int        exp_cyc;
  } exp_t;

  exp_t               sb[$];
  Word_t              model_mem [Ram_addr_t];
  Word_t              last_dread = '0;
  bit                 last_dbus  = 1'b0;
  bit                 saw_read_op = 1'b0;

  task automatic push_exp(input bit is_dbus, input bit wr, input Ram_addr_t a,
                          input Word_t wd, input Byte_mask_t m, input int exp_cyc);
    exp_t  e;
    Word_t cur;
    e.is_dbus = is_dbus;
    e.addr    = a;
    e.exp_cyc = exp_cyc;
    if (is_dbus && wr) begin
      cur = model_mem.exists(a) ? model_mem[a] : '0;
      for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = wd[8*b +: 8];
      model_mem[a] = cur;
      e.data = last_dread;
    end else begin
      e.data = model_mem.exists(a) ? model_mem[a] : '0;
      if (is_dbus) last_dread = e.data;
    end
    last_dbus = is_dbus;
    sb.push_back(e);
  endtask

  // Monitor: pop one expectation per ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (ctrl_read_op) saw_read_op = 1'b1;
    if (!rst && (ibus_ready || dbus_ready)) begin
      check("ready_onehot", ibus_ready & dbus_ready, 0);
      check("ready_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ready_port", dbus_ready, e.is_dbus);
        check("ready_cycle", cyc, e.exp_cyc);
        check(e.is_dbus ? "dbus_data" : "ibus_data",
              e.is_dbus ? dbus_data_read : ibus_data_read, e.data);
        $display("txn %s addr=0x%05h data=0x%08h cycle=%0d",
                 e.is_dbus ? "dbus" : "ibus", e.addr,
                 e.is_dbus ? dbus_data_read : ibus_data_read, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input bit is_dbus);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_dbus ? dbus_ready : ibus_ready;
    end
    if (!got) check(is_dbus ? "dbus_ready_timeout" : "ibus_ready_timeout", got, 1);
    #1;
  endtask

  task automatic drop(input bit is_dbus);
    if (is_dbus) begin
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
    end else begin
      ibus_read = 1'b0;
    end
  endtask

  task automatic xfer(input bit is_dbus, input bit rd, input bit wr, input Ram_addr_t a,
                      input Word_t wd, input Byte_mask_t m);
    push_exp(is_dbus, wr, a, wd, m, cyc + AC + 1);
    if (is_dbus) begin
      dbus_addr       = a;
      dbus_read       = rd;
      dbus_write      = wr;
      dbus_data_write = wd;
      dbus_byte_mask  = m;
    end else begin
      ibus_addr = a;
      ibus_read = 1'b1;
    end
    wait_ready(is_dbus);
    drop(is_dbus);
    step();
  endtask

  initial begin
    int  c;
    bit  dbus_first;
    rst = 1'b1;
    ibus_addr = '0; ibus_read = 1'b0;
    dbus_addr = '0; dbus_read = 1'b0; dbus_write = 1'b0;
    dbus_data_write = '0; dbus_byte_mask = '0;
    repeat (3) step();
    #3;
    check("rst_ctrl_ops", {ctrl_read_op, ctrl_write_op}, 0);
    check("rst_ctrl_addr", ctrl_addr, 0);
    check("rst_ctrl_mask", ctrl_byte_mask, 0);
    check("rst_ready", {ibus_ready, dbus_ready}, 0);
    check("rst_data_read", {ibus_data_read, dbus_data_read}, 0);
    step();
    rst = 1'b0;
    step();

    // Write then fetch the same word.
    xfer(1, 0, 1, 20'h00010, 32'hDEADBEEF, 4'b1111);
    xfer(0, 1, 0, 20'h00010, '0, 4'b1111);

    // Partial-byte store over an existing word.
    xfer(1, 0, 1, 20'h00020, 32'hAAAAAAAA, 4'b1111);
    xfer(1, 0, 1, 20'h00020, 32'h11223344, 4'b0011);
    xfer(1, 1, 0, 20'h00020, '0, 4'b1111);

    // Simultaneous requests.
    xfer(1, 0, 1, 20'h00004, 32'h04040404, 4'b1111);
    xfer(1, 0, 1, 20'h00008, 32'h08080808, 4'b1111);
    c = cyc;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    dbus_first = !last_dbus;
`else
    dbus_first = 1'b1;
`endif
    if (dbus_first) begin
      push_exp(1, 0, 20'h00008, '0, 4'b1111, c + AC + 1);
      push_exp(0, 0, 20'h00004, '0, 4'b1111, c + 2*AC + 3);
    end else begin
      push_exp(0, 0, 20'h00004, '0, 4'b1111, c + AC + 1);
      push_exp(1, 0, 20'h00008, '0, 4'b1111, c + 2*AC + 3);
    end
    ibus_addr = 20'h00004; ibus_read = 1'b1;
    dbus_addr = 20'h00008; dbus_read = 1'b1; dbus_byte_mask = 4'b1111;
    wait_ready(dbus_first);
    drop(dbus_first);
    wait_ready(!dbus_first);
    drop(!dbus_first);
    step();

    // Read+write together is a write; no read op on the controller.
    saw_read_op = 1'b0;
    xfer(1, 1, 1, 20'h00030, 32'h55AA55AA, 4'b1111);
    check("rw_no_read_op", saw_read_op, 0);
    xfer(1, 1, 0, 20'h00030, '0, 4'b1111);

    // Address change mid-ACCESS must not reach the controller.
    push_exp(1, 0, 20'h00010, '0, 4'b1111, cyc + AC + 1);
    dbus_addr = 20'h00010; dbus_read = 1'b1;
    step();
    dbus_addr = 20'h00020;
    #3;
    check("hold_addr_first", ctrl_addr, 20'h00010);
    step();
    #3;
    check("hold_addr_second", ctrl_addr, 20'h00010);
    check("hold_read_op", ctrl_read_op, 1);
    wait_ready(1);
    drop(1);
    step();

    // Reset in the middle of an access aborts it with no ready pulse.
    ibus_addr = 20'h00008; ibus_read = 1'b1;
    step();
    check("abort_access_active", ctrl_read_op, 1);
    rst = 1'b1;
    #1;
    check("abort_ctrl_ops", {ctrl_read_op, ctrl_write_op}, 0);
    check("abort_ctrl_addr", ctrl_addr, 0);
    ibus_read = 1'b0;
    last_dread = '0;
    last_dbus  = 1'b0;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("abort_no_pending", sb.size(), 0);
    check("abort_ibus_data", ibus_data_read, 0);
    xfer(0, 1, 0, 20'h00008, '0, 4'b1111);
    xfer(1, 1, 0, 20'h00004, '0, 4'b1111);

    repeat (2) step();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
